// File: rtl/mux8_arbiter_pkg.sv
// Shared definitions for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

  localparam int NREQ  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Expand a requester index into its one-hot grant vector.
  function automatic logic [NREQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mux8_arbiter_if.sv
// Request/grant bundle between the requesting units and the arbiter.
interface mux8_arbiter_if;
  import mux8_arb_pkg::*;

  logic [NREQ-1:0]  req;
  logic             done;
  logic [NREQ-1:0]  gnt;
  logic [SEL_W-1:0] sel;
  logic             active;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt, sel, active, timeout
  );

  modport slave (
    input  req, done,
    output gnt, sel, active, timeout
  );

endinterface

// File: rtl/mux8_arbiter_rr_pick8.sv
// Combinational round-robin picker: first set request at or after i_ptr.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [NREQ-1:0]  i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_hit,
  output logic [SEL_W-1:0] o_idx
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [SEL_W-1:0]  w_pe;

  // Rotate so that i_ptr lands at bit 0; the doubled copy supplies the wrap.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[NREQ-1:0];

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    w_pe = {SEL_W{1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_pe = w_rot[i] ? SEL_W'(i) : w_pe;
    end
  end

  // Un-rotate: the 3-bit add wraps modulo 8 on its own.
  assign o_hit = |i_req;
  assign o_idx = w_pe + i_ptr;

endmodule

// File: rtl/mux8_arbiter.sv
// Round-robin arbiter and select sequencer for the 32-bit 8:1 datapath mux.
module mux8_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  mux8_arbiter_if.slave  bus
);

  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int HL    = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HL);

  arb_state_t       r_state, w_state_n;
  logic [SEL_W-1:0] r_ptr, w_ptr_n;
  logic [SEL_W-1:0] r_owner, w_owner_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [NREQ-1:0]  r_gnt, w_gnt_n;
  logic [SEL_W-1:0] r_sel, w_sel_n;
  logic             r_active, w_active_n;
  logic             r_timeout, w_timeout_n;

  logic [SEL_W-1:0] w_pick_ptr;
  logic             w_hit;
  logic [SEL_W-1:0] w_idx;
  logic             w_owner_req;
  logic             w_hold_exp;
  logic             w_release;

  // While holding, the picker already looks from owner+1, so the same
  // instance serves both the idle pick and the back-to-back re-pick.
  assign w_pick_ptr = (r_state == ST_GRANT) ? (r_owner + 3'd1) : r_ptr;

  rr_pick8 u_pick (
    .i_req (bus.req),
    .i_ptr (w_pick_ptr),
    .o_hit (w_hit),
    .o_idx (w_idx)
  );

  assign w_owner_req = bus.req[r_owner];
  assign w_hold_exp  = (MAX_HOLD != 0) && (r_cnt == CNT_LAST);
  assign w_release   = bus.done || !w_owner_req || w_hold_exp;

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    w_state_n   = r_state;
    w_ptr_n     = r_ptr;
    w_owner_n   = r_owner;
    w_cnt_n     = r_cnt;
    w_gnt_n     = r_gnt;
    w_sel_n     = r_sel;
    w_active_n  = r_active;
    w_timeout_n = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_state_n  = ST_GRANT;
          w_owner_n  = w_idx;
          w_sel_n    = w_idx;
          w_gnt_n    = idx2onehot(w_idx);
          w_active_n = 1'b1;
          w_cnt_n    = {CNT_W{1'b0}};
        end else begin
          w_gnt_n    = {NREQ{1'b0}};
          w_active_n = 1'b0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_ptr_n     = r_owner + 3'd1;
          // Timeout is reported only when neither done nor abort caused the release.
          w_timeout_n = !bus.done && w_owner_req && w_hold_exp;
          if (w_hit) begin
            w_owner_n  = w_idx;
            w_sel_n    = w_idx;
            w_gnt_n    = idx2onehot(w_idx);
            w_active_n = 1'b1;
            w_cnt_n    = {CNT_W{1'b0}};
          end else begin
            w_state_n  = ST_IDLE;
            w_gnt_n    = {NREQ{1'b0}};
            w_active_n = 1'b0;
          end
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_n  = ST_IDLE;
        w_gnt_n    = {NREQ{1'b0}};
        w_active_n = 1'b0;
      end
    endcase
  end

  // State, bookkeeping and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= {SEL_W{1'b0}};
      r_owner   <= {SEL_W{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_gnt     <= {NREQ{1'b0}};
      r_sel     <= {SEL_W{1'b0}};
      r_active  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_ptr     <= w_ptr_n;
      r_owner   <= w_owner_n;
      r_cnt     <= w_cnt_n;
      r_gnt     <= w_gnt_n;
      r_sel     <= w_sel_n;
      r_active  <= w_active_n;
      r_timeout <= w_timeout_n;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.sel     = r_sel;
  assign bus.active  = r_active;
  assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_mux8_arbiter.sv
// Directed scoreboard bench for mux8_arbiter (hold limit set to 4).
module tb_mux8_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mux8_arbiter_if bus ();

  mux8_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected packed as {gnt[7:0], sel[2:0], active, timeout}.
  logic [12:0] exp_q[$];
  string       tag_q[$];

  function automatic logic [12:0] pack(input logic [7:0] g, input logic [2:0] s,
                                       input logic a, input logic t);
    return {g, s, a, t};
  endfunction

  task automatic compare(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = {bus.gnt, bus.sel, bus.active, bus.timeout};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed gnt=%h sel=%0d act=%b to=%b expected gnt=%h sel=%0d act=%b to=%b",
             tag, obs[12:5], obs[4:2], obs[1], obs[0], exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, then check after the edge.
  task automatic step(input string tag, input logic [7:0] r, input logic d,
                      input logic [7:0] g, input logic [2:0] s,
                      input logic a, input logic t);
    logic [12:0] e;
    string       tg;
    bus.req  = r;
    bus.done = d;
    exp_q.push_back(pack(g, s, a, t));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    tg = tag_q.pop_front();
    compare(tg, e);
  endtask

  initial begin
    logic [7:0] oh;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    #1;
    compare("reset_state", pack(8'h00, 3'd0, 1'b0, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Asynchronous reset mid-grant, then restart from index 0.
    step("grant_idx4", 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    compare("async_reset", pack(8'h00, 3'd0, 1'b0, 1'b0));
    #1;
    rst = 1'b0;
    step("post_reset_ff", 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);

    // Full rotation with done every cycle.
    for (int i = 1; i <= 8; i++) begin
      oh = 8'h01 << (i % 8);
      step($sformatf("rotate_%0d", i), 8'hFF, 1'b1, oh, 3'(i % 8), 1'b1, 1'b0);
    end
    step("rotate_to_idle", 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

    // Single requester, done with request withdrawn; sel holds.
    step("single_grant", 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    step("single_done", 8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);

    // Wrap-around 7 -> 0 -> 7.
    step("wrap_grant7", 8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
    step("wrap_to0", 8'h81, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
    step("wrap_to7", 8'h81, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0);
    step("wrap_idle", 8'h00, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0);

    // Timeout: index 2 holds 4 cycles then index 5 takes over.
    step("to_grant2", 8'h24, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step($sformatf("to_hold2_%0d", i), 8'h24, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    step("to_fire_5", 8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      step($sformatf("to_hold5_%0d", i), 8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    step("to_fire_2", 8'h24, 1'b0, 8'h04, 3'd2, 1'b1, 1'b1);

    // done coincident with the limit: release without timeout.
    for (int i = 0; i < 3; i++)
      step($sformatf("co_hold_%0d", i), 8'h24, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    step("co_done_limit", 8'h24, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0);
    step("co_idle", 8'h00, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0);

    // Abort: holder 1 drops its request, pending 3 is granted.
    step("abort_grant1", 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
    step("abort_next3", 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    step("abort_idle", 8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);
    step("idle_done_ignored", 8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
